booth_mult: RTL and testbench



---
 rtl/booth_mult_pkg.sv | 13 +
 rtl/booth_mult_if.sv | 26 ++
 rtl/booth_step.sv | 32 +++
 rtl/booth_mult.sv | 113 +++++++++++
 tb/tb_booth_mult.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/booth_mult_pkg.sv
// rtl/booth_mult_pkg.sv - shared types and constants for the Booth multiplier
package booth_mult_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_mult_if.sv
// rtl/booth_mult_if.sv - start/operand/product handshake bundle for booth_mult
interface booth_mult_if
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, a, b,
        output hi, lo, busy, done
    );

endinterface

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth iteration (add/sub + arithmetic shift)
module booth_step
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_1_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
    end

    // Shift {sum, q, q_1} right by one, replicating the accumulator sign bit
    assign acc_next = {sum[WIDTH], sum[WIDTH:1]};
    assign q_next   = {sum[0], q[WIDTH-1:1]};
    assign q_1_next = q[0];

endmodule

// File: rtl/booth_mult.sv
// rtl/booth_mult.sv - sequential signed Booth multiplier top; BOOTH_ZERO_SKIP_EN enables zero-operand bypass
module booth_mult
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    booth_mult_if.slave   bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           next_state;
    logic [WIDTH:0]   m;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc_n;
    logic [WIDTH-1:0] q_n;
    logic             q_1_n;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;
    logic             last_iter;
    logic             zero_skip;

    assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero_skip = (bus.a == '0) || (bus.b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .q        (q),
        .q_1      (q_1),
        .m        (m),
        .acc_next (acc_n),
        .q_next   (q_n),
        .q_1_next (q_1_n)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = zero_skip ? DONE : RUN;
            RUN:     if (last_iter) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // busy/done are registered from next_state so they line up with the state they describe
    always_ff @(posedge clock) begin
        if (reset) begin
            m      <= '0;
            acc    <= '0;
            q      <= '0;
            q_1    <= 1'b0;
            cnt    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state != IDLE);
            done_r <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m   <= {bus.a[WIDTH-1], bus.a};
                        acc <= '0;
                        q   <= bus.b;
                        q_1 <= 1'b0;
                        cnt <= '0;
                        if (zero_skip) begin
                            hi_r <= '0;
                            lo_r <= '0;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_n;
                    q   <= q_n;
                    q_1 <= q_1_n;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        hi_r <= acc_n[WIDTH-1:0];
                        lo_r <= q_n;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_booth_mult.sv
// tb/tb_booth_mult.sv - directed scoreboard bench for booth_mult
module tb_booth_mult;

    logic clock = 1'b0;
    logic reset = 1'b1;

    booth_mult_if #(.WIDTH(32)) bus ();

    booth_mult #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb[$];
    logic [63:0] last_prod = 64'd0;

`ifdef BOOTH_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        return sx * sy;
    endfunction

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [63:0] exp, input int exp_lat, input int ignore_at);
        int          n;
        logic        got;
        logic        busy_ok;
        logic [63:0] exp_v;
        sb.push_back(exp);
        @(negedge clock);
        bus.a     = ta;
        bus.b     = tb_v;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        n         = 1;
        got       = 1'b0;
        busy_ok   = 1'b1;
        while (n <= 40 && !got) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (n == 5) check({tag, "_hold"}, {bus.hi, bus.lo}, last_prod);
                bus.start = (n == ignore_at);
                @(negedge clock);
                n++;
            end
        end
        bus.start = 1'b0;
        exp_v = sb.pop_front();
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, "_latency"}, 64'(n), 64'(exp_lat));
            check({tag, "_busy"}, 64'(busy_ok), 64'd1);
            check({tag, "_product"}, {bus.hi, bus.lo}, exp_v);
            last_prod = exp_v;
            @(negedge clock);
            check({tag, "_after_done"}, {62'd0, bus.busy, bus.done}, 64'd0);
            check({tag, "_after_hold"}, {bus.hi, bus.lo}, exp_v);
        end
    endtask

    initial begin
        logic        saw_done;
        logic [31:0] ra;
        logic [31:0] rb;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);

        run_op("p3x5", 32'd3, 32'd5, 64'h00000000_0000000F, 33, 0);
        run_op("neg1x1", 32'hFFFFFFFF, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 33, 0);
        run_op("min_sq", 32'h80000000, 32'h80000000, 64'h40000000_00000000, 33, 0);
        run_op("max_sq", 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 33, 10);

        saw_done = 1'b0;
        repeat (5) begin
            if (bus.done || bus.busy) saw_done = 1'b1;
            @(negedge clock);
        end
        check("ignored_start_idle", 64'(saw_done), 64'd0);
        check("ignored_start_hold", {bus.hi, bus.lo}, 64'h3FFFFFFF_00000001);

        bus.a     = 32'd7;
        bus.b     = 32'd9;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        saw_done  = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (bus.done) saw_done = 1'b1;
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        repeat (40) begin
            if (bus.done) saw_done = 1'b1;
            @(negedge clock);
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        last_prod = 64'd0;

        run_op("m6x7", 32'hFFFFFFFA, 32'd7, 64'hFFFFFFFF_FFFFFFD6, 33, 0);

        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        @(negedge clock);
        reset     = 1'b0;
        bus.start = 1'b0;
        check("reset_wins_busy", 64'(bus.busy), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            if (bus.done || bus.busy) saw_done = 1'b1;
            @(negedge clock);
        end
        check("reset_wins_idle", 64'(saw_done), 64'd0);
        last_prod = 64'd0;

        run_op("nz_prime", 32'd11, 32'd13, 64'd143, 33, 0);
        run_op("zero_a", 32'd0, 32'h00001234, 64'd0, ZERO_LAT, 0);

        for (int k = 0; k < 3; k++) begin
            ra = $urandom;
            rb = $urandom;
            run_op("rand", ra, rb, model(ra, rb), 33, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
